// File: rtl/alu_seq.sv
// Registered ALU with valid/ready input. The shift-add MUL (opcode 110) is built only when ALU_SEQ_MUL_EN is defined.
// Latency: 1 edge for single-cycle ops, WIDTH enabled edges for MUL.
// Backpressure: in_ready is low while a MUL is in flight or enable is low. No output backpressure.
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       opcode,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_hi,
    output logic             cout,
    output logic             zero,
    output logic             err,
    output logic             out_valid
);

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_PASS = 3'b011;
    localparam logic [2:0] OP_OR   = 3'b100;
    localparam logic [2:0] OP_XOR  = 3'b101;

    logic             accept;
    logic [WIDTH-1:0] alu_res;
    logic             alu_cout;
    logic             alu_err;

    logic             wr_en;
    logic [WIDTH-1:0] wr_lo;
    logic             wr_cout;
    logic             wr_err;
    logic             wr_zero;

    // Single-cycle datapath. Anything not decoded here, including 110 when MUL is absent, is reserved.
    always_comb begin
        alu_res  = '0;
        alu_cout = 1'b0;
        alu_err  = 1'b0;
        case (opcode)
            OP_ADD:  {alu_cout, alu_res} = {1'b0, A} + {1'b0, B};
            OP_SUB:  {alu_cout, alu_res} = {1'b0, A} - {1'b0, B};
            OP_AND:  alu_res = A & B;
            OP_PASS: alu_res = A;
            OP_OR:   alu_res = A | B;
            OP_XOR:  alu_res = A ^ B;
            default: alu_err = 1'b1;
        endcase
    end

`ifdef ALU_SEQ_MUL_EN
    localparam logic [2:0] OP_MUL = 3'b110;
    localparam int         CW     = $clog2(WIDTH) + 1;

    typedef enum logic {
        IDLE,
        MUL
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   mult;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_step;
    logic               mul_start;
    logic               mul_done;
    logic [WIDTH-1:0]   wr_hi;

    assign in_ready  = enable && (state == IDLE);
    assign accept    = in_valid && in_ready;
    assign mul_start = accept && (opcode == OP_MUL);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // acc_step is the accumulator after this cycle's partial product, so the last step can write it out directly.
    always_comb begin
        state_nxt = state;
        acc_step  = acc;
        mul_done  = 1'b0;
        if (state == IDLE) begin
            if (mul_start) begin
                state_nxt = MUL;
            end
        end else if (enable) begin
            if (mult[0]) begin
                acc_step = acc + ({{WIDTH{1'b0}}, mcand} << cnt);
            end
            if (cnt == CW'(WIDTH - 1)) begin
                mul_done  = 1'b1;
                state_nxt = IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            mcand <= '0;
            mult  <= '0;
            acc   <= '0;
        end else if (mul_start) begin
            cnt   <= '0;
            mcand <= A;
            mult  <= B;
            acc   <= '0;
        end else if (state == MUL && enable) begin
            cnt   <= cnt + CW'(1);
            mult  <= mult >> 1;
            acc   <= acc_step;
        end
    end

    always_comb begin
        wr_en   = accept && !mul_start;
        wr_lo   = alu_res;
        wr_hi   = '0;
        wr_cout = alu_cout;
        wr_err  = alu_err;
        if (mul_done) begin
            wr_en          = 1'b1;
            {wr_hi, wr_lo} = acc_step;
            wr_cout        = 1'b0;
            wr_err         = 1'b0;
        end
        wr_zero = ({wr_hi, wr_lo} == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_hi <= '0;
        end else if (wr_en) begin
            out_hi <= wr_hi;
        end
    end
`else
    assign in_ready = enable;
    assign accept   = in_valid && in_ready;
    assign out_hi   = '0;

    always_comb begin
        wr_en   = accept;
        wr_lo   = alu_res;
        wr_cout = alu_cout;
        wr_err  = alu_err;
        wr_zero = (alu_res == '0);
    end
`endif

    // Result registers hold until the next completing op; out_valid self-clears even with enable low.
    always_ff @(posedge clk) begin
        if (rst) begin
            out       <= '0;
            cout      <= 1'b0;
            zero      <= 1'b1;
            err       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (wr_en) begin
                out       <= wr_lo;
                cout      <= wr_cout;
                zero      <= wr_zero;
                err       <= wr_err;
                out_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Randomised and directed bench for alu_seq against a plain-arithmetic reference model.
module tb_alu_seq;
    localparam int W = 8;
`ifdef ALU_SEQ_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         enable;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   opcode;
    logic [W-1:0] out;
    logic [W-1:0] out_hi;
    logic         cout;
    logic         zero;
    logic         err;
    logic         out_valid;

    int checks   = 0;
    int failures = 0;

    alu_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .enable(enable), .in_valid(in_valid), .in_ready(in_ready),
        .A(a), .B(b), .opcode(opcode), .out(out), .out_hi(out_hi), .cout(cout),
        .zero(zero), .err(err), .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain integer arithmetic; lat is edges after the accept edge until out_valid.
    function automatic void model(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                                  output logic [W-1:0] lo, output logic [W-1:0] hi,
                                  output logic c, output logic z, output logic e, output int lat);
        longint unsigned r;
        r   = 0;
        c   = 1'b0;
        e   = 1'b0;
        lat = 0;
        hi  = '0;
        case (op)
            3'd0: begin r = x; r = r + y; c = r[W]; end
            3'd1: begin r = x; r = r + (64'd1 << W) - y; c = (x < y); end
            3'd2: r = x & y;
            3'd3: r = x;
            3'd4: r = x | y;
            3'd5: r = x ^ y;
            3'd6: begin
                if (MUL_EN) begin
                    r   = x;
                    r   = r * y;
                    hi  = r[2*W-1:W];
                    lat = W;
                end else begin
                    e = 1'b1;
                end
            end
            default: e = 1'b1;
        endcase
        lo = r[W-1:0];
        z  = (lo == '0) && (hi == '0);
    endfunction

    // Presents one op, clocks the accept edge and waits (bounded) for out_valid.
    task automatic do_op(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                         output int lat, output bit rdy_acc, output bit rdy_busy);
        opcode   = op;
        a        = x;
        b        = y;
        in_valid = 1'b1;
        #1;
        rdy_acc = in_ready;
        tick();
        in_valid = 1'b0;
        lat      = 0;
        rdy_busy = 1'b0;
        while (!out_valid && lat < 64) begin
            if (in_ready) rdy_busy = 1'b1;
            tick();
            lat++;
        end
        if (!out_valid) lat = -1;
    endtask

    task automatic test_reset();
        int seen;
        rst = 1'b1; enable = 1'b0; in_valid = 1'b0; a = '0; b = '0; opcode = '0;
        tick(); tick();
        checks++;
        if ({out_hi, out, cout, zero, err, out_valid, in_ready} !== {8'h00, 8'h00, 5'b01000}) begin
            failures++;
            $display("FAIL reset_state got=%h %h c%b z%b e%b v%b r%b", out_hi, out, cout, zero, err, out_valid, in_ready);
        end
        rst = 1'b0; enable = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL ready_after_reset got=%b exp=1", in_ready); end
        opcode = 3'd0; a = 8'hF0; b = 8'h20; in_valid = 1'b1;
        tick();
        opcode = 3'd6; a = 8'hFF; b = 8'hFF;
        tick();
        in_valid = 1'b0;
        checks++;
        if (out !== (MUL_EN ? 8'h10 : 8'h00)) begin
            failures++; $display("FAIL mul_accept_holds_out got=%h exp=%h", out, MUL_EN ? 8'h10 : 8'h00);
        end
        tick(); tick();
        enable = 1'b0; rst = 1'b1;
        tick();
        checks++;
        if ({out_hi, out, cout, zero, err, out_valid, in_ready} !== {8'h00, 8'h00, 4'b0100, enable}) begin
            failures++;
            $display("FAIL reset_mid_mul got=%h %h c%b z%b e%b v%b r%b", out_hi, out, cout, zero, err, out_valid, in_ready);
        end
        rst = 1'b0; enable = 1'b1;
        seen = 0;
        repeat (12) begin
            tick();
            if (out_valid) seen++;
        end
        checks++;
        if (seen !== 0) begin failures++; $display("FAIL aborted_mul_valid got=%0d exp=0", seen); end
    endtask

    task automatic test_addsub();
        logic [7:0] va [3] = '{8'hF0, 8'h05, 8'h07};
        logic [7:0] vb [3] = '{8'h20, 8'h07, 8'h07};
        logic [2:0] vo [3] = '{3'd0, 3'd1, 3'd1};
        logic [W-1:0] elo, ehi;
        logic ec, ez, ee;
        int elat, lat;
        bit ra, rb;
        for (int i = 0; i < 3; i++) begin
            model(vo[i], va[i], vb[i], elo, ehi, ec, ez, ee, elat);
            do_op(vo[i], va[i], vb[i], lat, ra, rb);
            checks++;
            if (lat !== elat || ra !== 1'b1) begin
                failures++; $display("FAIL addsub_latency[%0d] got=%0d rdy=%b exp=%0d", i, lat, ra, elat);
            end
            checks++;
            if ({out_hi, out, cout, zero, err} !== {ehi, elo, ec, ez, ee}) begin
                failures++;
                $display("FAIL addsub_result[%0d] got=%h%h c%b z%b e%b exp=%h%h c%b z%b e%b",
                         i, out_hi, out, cout, zero, err, ehi, elo, ec, ez, ee);
            end
            tick();
            checks++;
            if (out_valid !== 1'b0) begin failures++; $display("FAIL addsub_pulse[%0d] got=%b exp=0", i, out_valid); end
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] ops [4] = '{3'd2, 3'd4, 3'd5, 3'd3};
        logic [W-1:0] elo, ehi;
        logic ec, ez, ee;
        int elat;
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            opcode = ops[i];
            a = W'($urandom);
            b = W'($urandom);
            model(ops[i], a, b, elo, ehi, ec, ez, ee, elat);
            tick();
            checks++;
            if ({out_valid, out_hi, out, cout, zero, err} !== {1'b1, ehi, elo, ec, ez, ee}) begin
                failures++;
                $display("FAIL b2b[%0d] got=v%b %h%h c%b z%b e%b exp=%h%h c%b z%b e%b",
                         i, out_valid, out_hi, out, cout, zero, err, ehi, elo, ec, ez, ee);
            end
        end
        in_valid = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_end got=%b exp=0", out_valid); end
    endtask

    task automatic test_mul();
        logic [7:0] va [2] = '{8'hFF, 8'h00};
        logic [7:0] vb [2] = '{8'hFF, 8'h37};
        logic [W-1:0] elo, ehi;
        logic ec, ez, ee;
        int elat, lat;
        bit ra, rb;
        for (int i = 0; i < 2; i++) begin
            model(3'd6, va[i], vb[i], elo, ehi, ec, ez, ee, elat);
            do_op(3'd6, va[i], vb[i], lat, ra, rb);
            checks++;
            if (lat !== elat || rb !== 1'b0) begin
                failures++; $display("FAIL mul_latency[%0d] got=%0d busy_rdy=%b exp=%0d", i, lat, rb, elat);
            end
            checks++;
            if ({out_hi, out, cout, zero, err} !== {ehi, elo, ec, ez, ee}) begin
                failures++;
                $display("FAIL mul_result[%0d] got=%h%h c%b z%b e%b exp=%h%h c%b z%b e%b",
                         i, out_hi, out, cout, zero, err, ehi, elo, ec, ez, ee);
            end
            tick();
            checks++;
            if ({out_valid, in_ready} !== 2'b01) begin
                failures++; $display("FAIL mul_after[%0d] got=v%b r%b exp=v0 r1", i, out_valid, in_ready);
            end
        end
    endtask

    task automatic test_stall();
        logic [W-1:0] elo, ehi;
        logic ec, ez, ee;
        int elat, lat;
        bit rdy_bad;
        model(3'd6, 8'h0C, 8'h0B, elo, ehi, ec, ez, ee, elat);
        opcode = 3'd6; a = 8'h0C; b = 8'h0B; in_valid = 1'b1;
        tick();
        lat = 0;
        rdy_bad = 1'b0;
        while (!out_valid && lat < 64) begin
            enable = !(lat >= 2 && lat <= 4);
            #1;
            if (!enable && in_ready) rdy_bad = 1'b1;
            tick();
            lat++;
        end
        in_valid = 1'b0;
        enable = 1'b1;
        if (!out_valid) lat = -1;
        checks++;
        if (lat !== (elat == 0 ? 0 : elat + 3) || rdy_bad) begin
            failures++; $display("FAIL stall_latency got=%0d rdy_bad=%b exp=%0d", lat, rdy_bad, elat == 0 ? 0 : elat + 3);
        end
        checks++;
        if ({out_hi, out, cout, zero, err} !== {ehi, elo, ec, ez, ee}) begin
            failures++; $display("FAIL stall_result got=%h%h e%b exp=%h%h e%b", out_hi, out, err, ehi, elo, ee);
        end
        // Disabled block must ignore a presented op and still drop out_valid.
        enable = 1'b0; opcode = 3'd0; a = 8'h11; b = 8'h22; in_valid = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin failures++; $display("FAIL disabled_ready got=%b exp=0", in_ready); end
        tick();
        checks++;
        if ({out_valid, out_hi, out} !== {1'b0, ehi, elo}) begin
            failures++; $display("FAIL disabled_hold got=v%b %h%h exp=v0 %h%h", out_valid, out_hi, out, ehi, elo);
        end
        in_valid = 1'b0; enable = 1'b1;
    endtask

    task automatic test_reserved();
        logic [2:0] ops [2] = '{3'd7, 3'd6};
        logic [W-1:0] elo, ehi;
        logic ec, ez, ee;
        int elat, lat;
        bit ra, rb;
        for (int i = 0; i < 2; i++) begin
            logic [W-1:0] x, y;
            x = W'($urandom_range(1, 255));
            y = W'($urandom_range(1, 255));
            model(ops[i], x, y, elo, ehi, ec, ez, ee, elat);
            do_op(ops[i], x, y, lat, ra, rb);
            checks++;
            if (lat !== elat || {out_hi, out, cout, zero, err} !== {ehi, elo, ec, ez, ee}) begin
                failures++;
                $display("FAIL reserved[%0d] lat=%0d got=%h%h c%b z%b e%b exp lat=%0d %h%h c%b z%b e%b",
                         i, lat, out_hi, out, cout, zero, err, elat, ehi, elo, ec, ez, ee);
            end
            tick();
        end
    endtask

    task automatic test_random();
        logic [W-1:0] elo, ehi, x, y;
        logic [2:0] op;
        logic ec, ez, ee;
        int elat, lat;
        bit ra, rb;
        for (int i = 0; i < 60; i++) begin
            op = 3'($urandom_range(0, 7));
            x  = W'($urandom);
            y  = W'($urandom);
            model(op, x, y, elo, ehi, ec, ez, ee, elat);
            do_op(op, x, y, lat, ra, rb);
            checks++;
            if (lat !== elat || ra !== 1'b1 || rb !== 1'b0 ||
                {out_hi, out, cout, zero, err} !== {ehi, elo, ec, ez, ee}) begin
                failures++;
                $display("FAIL random[%0d] op=%0d a=%h b=%h lat=%0d r%b%b got=%h%h c%b z%b e%b exp lat=%0d %h%h c%b z%b e%b",
                         i, op, x, y, lat, ra, rb, out_hi, out, cout, zero, err, elat, ehi, elo, ec, ez, ee);
            end
            if ($urandom_range(0, 1) == 1) tick();
        end
    endtask

    initial begin
        test_reset();
        test_addsub();
        test_back_to_back();
        test_mul();
        test_stall();
        test_reserved();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, registered successor to the team's 4-bit combinational ALU. Accepts one operation per cycle through a valid/ready handshake, registers result and flags, and adds a multi-cycle shift-add multiplier, zero/error flags and a clock-enable that freezes all state. It sits between the operand register file and the writeback stage of the datapath.

## Interface
- `WIDTH`, default 8: operand and result width; legal range 2 to 32.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `enable`  in  1  clock enable. When low, no state changes except the `out_valid` clear.
- `in_valid`  in  1  operands and opcode are valid.
- `in_ready`  out  1  block can accept. Combinational: `enable && state==IDLE`.
- `A`  in  WIDTH  operand A.
- `B`  in  WIDTH  operand B.
- `opcode`  in  3  operation select.
- `out`  out  WIDTH  result, or the low half of the product.
- `out_hi`  out  WIDTH  high half of the product. 0 for all other ops.
- `cout`  out  1  carry for ADD, borrow for SUB, 0 otherwise.
- `zero`  out  1  `{out_hi,out}==0`.
- `err`  out  1  reserved or disabled opcode.
- `out_valid`  out  1  one-cycle pulse: the result registers were updated.

## Operation
- An accept occurs at any rising edge where `in_valid && in_ready`.
- Opcodes:
  - 000 ADD: `{cout,out}=A+B`.
  - 001 SUB: `{cout,out}={1'b0,A}-{1'b0,B}`, so `cout=1` iff A<B.
  - 010 AND.
  - 011 PASS A.
  - 100 OR.
  - 101 XOR.
  - 110 MUL: unsigned, 2*WIDTH-bit result on `{out_hi,out}`.
  - 111 reserved.
- Reserved opcode: `out=0`, `out_hi=0`, `cout=0`, `zero=1`, `err=1`.
- All non-MUL ops are single-cycle. Result, flags and `out_valid=1` are registered at the accept edge.
- FSM states:
  - IDLE: non-MUL accept stays in IDLE; MUL accept goes to MUL.
  - MUL: performs one shift-add step per enabled cycle over WIDTH steps, then returns to IDLE.
- MUL accept actions: load the multiplicand, multiplier and a 2*WIDTH-bit accumulator cleared to 0; set step counter to 0; leave the output registers unchanged; `out_valid` stays 0.
- Each enabled cycle in MUL:
  - If the multiplier LSB is 1, add the multiplicand (shifted by the counter) to the accumulator.
  - Shift the multiplier right by one.
  - Increment the counter. The counter is `$clog2(WIDTH)+1` bits wide and wraps nowhere.
- At the step where the counter equals WIDTH-1: write the final product to `{out_hi,out}`, update `zero`, clear `cout` and `err`, pulse `out_valid`, and return to IDLE.
- Output registers hold their values until the next completing operation.

## Timing
- Reset: state=IDLE, counter=0, and `out`, `out_hi`, `cout`, `err`, `out_valid` are all 0. `zero`=1.
- Reset overrides `enable` and aborts an in-flight MUL with no `out_valid`.
- `in_ready` is high in the cycle following a reset release.
- Single-cycle ops: latency 1. For an accept at edge N, results are visible after edge N with `out_valid` high for cycle N..N+1. Back-to-back accepts every cycle give throughput 1 per clock.
- MUL: latency WIDTH edges. For an accept at edge N, `out_valid` pulses after edge N+WIDTH. `in_ready` is low from after edge N until after edge N+WIDTH.
- A new op may be accepted at edge N+WIDTH+1.
- `enable` low:
  - `in_ready`=0.
  - The MUL counter and accumulator hold.
  - Latency extends by exactly the number of disabled cycles.
  - `out_valid` still clears at the next edge, so it is never stretched beyond one cycle.
- `in_valid` while `in_ready`=0 is ignored. The upstream holds its request; this block never drops an accepted op.

## Configuration
- `ALU_SEQ_MUL_EN` defined: opcode 110 is MUL as described.
- `ALU_SEQ_MUL_EN` undefined:
  - Opcode 110 behaves as reserved: single cycle, `err=1`.
  - The MUL state, counter and accumulator are not synthesised, and `out_hi` is tied to 0.
  - All other timing is unchanged.

## Test plan
- Reset: assert `rst` with `enable=0` mid-MUL → the next cycle shows all outputs at reset values, `zero=1`, `in_ready=enable`, and no `out_valid`.
- ADD/SUB (WIDTH=8): ADD 0xF0+0x20 → out=0x10, cout=1, out_valid one cycle later. SUB 0x05−0x07 → out=0xFE, cout=1. SUB 0x07−0x07 → out=0, zero=1.
- Back-to-back: AND, OR, XOR, PASS on 4 consecutive edges with `in_valid` held high → 4 consecutive `out_valid` pulses with the correct results in order.
- MUL: 0xFF*0xFF → after exactly 8 edges `{out_hi,out}`=0xFE01, with `in_ready` low throughout. 0x00*0x37 → result 0 with zero=1.
- Stall: MUL 0x0C*0x0B with `enable` dropped for 3 cycles mid-operation → `out_valid` 11 edges after accept, `{out_hi,out}`=0x0084.
- Reserved and macro: opcode 111 → err=1, out=0, zero=1, latency 1. With `ALU_SEQ_MUL_EN` undefined, opcode 110 gives the same response.
